// File: rtl/sram_controller.sv
// sram_controller: splits single-cycle 32-bit word requests into two 16-bit
// SRAM accesses (low half first). Holds `ready` low while an access is in flight.
module sram_controller #(
    parameter logic [31:0] BASE_ADDR     = 32'd1024,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    inout  wire  [15:0] SRAM_DQ
);

    localparam int unsigned CntW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(ACCESS_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CntW-1:0] r_count;
    logic [15:0]     r_lo;
    logic [31:0]     r_read_data;

    logic            w_last;
    logic            w_count_clr;
    logic            w_addr_en;
    logic            w_half;
    logic            w_drive;
    logic [31:0]     w_offset;
    logic [16:0]     w_word;
    logic [15:0]     w_dq_out;
    logic            w_unused_off;

    assign w_offset     = address - BASE_ADDR;
    assign w_word       = w_offset[18:2];
    // Byte-lane bits and bits above the SRAM range have no meaning here.
    assign w_unused_off = ^{w_offset[31:19], w_offset[1:0]};

    assign w_last    = (r_count == LastCnt);
    assign w_dq_out  = w_half ? write_data[31:16] : write_data[15:0];
    assign SRAM_ADDR = w_addr_en ? {w_word, w_half} : 18'd0;
    assign SRAM_DQ   = w_drive ? w_dq_out : 16'hzzzz;
    assign read_data = r_read_data;

    // State register with asynchronous abort of any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Phase counter, restarted at the start of every phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_count_clr) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CntW'(1);
        end
    end

    // Capture the SRAM data on the edge that closes each read phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lo        <= 16'd0;
            r_read_data <= 32'd0;
        end else begin
            if (r_state == RD_LO && w_last) begin
                r_lo <= SRAM_DQ;
            end
            if (r_state == RD_HI && w_last) begin
                r_read_data <= {SRAM_DQ, r_lo};
            end
        end
    end

    // Next-state and bus-control decode.
    always_comb begin
        w_next_state = r_state;
        w_count_clr  = 1'b0;
        ready        = 1'b0;
        SRAM_WE_N    = 1'b1;
        w_addr_en    = 1'b0;
        w_half       = 1'b0;
        w_drive      = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_count_clr = 1'b1;
                if (wr_en) begin
                    w_next_state = WR_LO;
                end else if (rd_en) begin
                    w_next_state = RD_LO;
                end else begin
                    ready = 1'b1;
                end
            end
            RD_LO: begin
                w_addr_en = 1'b1;
                if (w_last) begin
                    w_next_state = RD_HI;
                    w_count_clr  = 1'b1;
                end
            end
            RD_HI: begin
                w_addr_en = 1'b1;
                w_half    = 1'b1;
                if (w_last) begin
                    w_next_state = DONE;
                    w_count_clr  = 1'b1;
                end
            end
            WR_LO: begin
                w_addr_en = 1'b1;
                SRAM_WE_N = 1'b0;
                w_drive   = 1'b1;
                if (w_last) begin
                    w_next_state = WR_HI;
                    w_count_clr  = 1'b1;
                end
            end
            WR_HI: begin
                w_addr_en = 1'b1;
                w_half    = 1'b1;
                SRAM_WE_N = 1'b0;
                w_drive   = 1'b1;
                if (w_last) begin
                    w_next_state = DONE;
                    w_count_clr  = 1'b1;
                end
            end
            DONE: begin
                // A request still held here is the one just completed.
                ready        = 1'b1;
                w_count_clr  = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_count_clr  = 1'b1;
                w_next_state = IDLE;
            end
        endcase
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Initiator side of the 16-bit external SRAM interface (SRAM_DQ / SRAM_ADDR / SRAM_WE_N); sits between the pipeline's memory stage and the SRAM.
- Converts single-cycle 32-bit word read/write requests into two sequential 16-bit SRAM accesses (low half first).
- Returns a `ready` handshake that the pipeline uses to freeze while an access is in flight.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM halfword 0; subtracted from `address`.
- ACCESS_CYCLES, 2: clock cycles each half-access phase lasts (≥1); covers the SRAM read delay.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  word write request.
- rd_en  input  1  word read request.
- address  input  32  byte address of the word.
- write_data  input  32  word to write.
- read_data  output  32  last word read, registered.
- ready  output  1  high = idle or completing; low = pipeline must freeze.
- SRAM_ADDR  output  18  SRAM halfword address.
- SRAM_WE_N  output  1  SRAM write enable, active-low.
- SRAM_DQ  inout  16  SRAM data bus; driven only while writing, else high-Z.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, read_data=0, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ=Z.
  - Takes effect immediately, including mid-access. The aborted access produces no DONE cycle. A partly written word may remain in SRAM.
- Address mapping:
  - off = address − BASE_ADDR (32-bit, wraps).
  - Low half uses SRAM_ADDR = {off[18:2],0}; high half uses {off[18:2],1}.
  - off[1:0] and off[31:19] are ignored.
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- ready is combinational:
  - 1 in DONE.
  - 1 in IDLE when rd_en=0 and wr_en=0.
  - 0 otherwise, i.e. falls in the same cycle a request appears in IDLE.
- IDLE:
  - wr_en=1 → WR_LO.
  - else rd_en=1 → RD_LO.
  - wr_en has priority if both are asserted.
  - Counter cleared on entry to every phase.
- Each LO/HI phase lasts exactly ACCESS_CYCLES cycles, then advances: LO→HI, HI→DONE.
- Read phases:
  - SRAM_WE_N=1, SRAM_DQ=Z, SRAM_ADDR per half.
  - SRAM_DQ is sampled on the edge closing the phase's last cycle; the low half goes to an internal register.
  - read_data={hi,lo} is loaded on the edge entering DONE. It holds until the next read completes; writes do not change it.
- Write phases:
  - SRAM_WE_N=0, SRAM_DQ=write_data[15:0] in WR_LO and write_data[31:16] in WR_HI, SRAM_ADDR per half.
  - The SRAM commits on every edge while WE_N=0; repeated commits are harmless.
- DONE:
  - One cycle, ready=1, SRAM_WE_N=1, SRAM_DQ=Z, then → IDLE unconditionally.
  - A request still asserted in DONE is treated as the completed one. It is re-serviced only if still asserted in the following IDLE cycle.
- Latency, cycle 0 = request seen in IDLE: ready=0 in cycles 0..2·ACCESS_CYCLES, ready=1 in cycle 2·ACCESS_CYCLES+1. With the default this is ready low in cycles 0–4 and high in cycle 5.
- Requester obligation: hold address, write_data, rd_en and wr_en stable until it samples ready=1. Changes mid-access give undefined data but no protocol lockup.
- Outside access phases, SRAM_ADDR=0 and SRAM_WE_N=1.
- SRAM_DQ is never driven when SRAM_WE_N=1, so there is no bus contention with the SRAM.

Test Plan:
- Reset, then idle with no requests → ready=1, SRAM_WE_N=1, SRAM_DQ=Z, read_data=0.
- Write 0x12345678 at address 1032 → ready low 5 cycles, then high 1 cycle.
  - SRAM_WE_N=0 with SRAM_ADDR=4, DQ=0x5678 for 2 cycles.
  - Then SRAM_ADDR=5, DQ=0x1234 for 2 cycles.
  - SRAM mem[4]=0x5678, mem[5]=0x1234.
- Read address 1032 after the write → SRAM_WE_N stays 1, SRAM_ADDR 4 then 5, read_data=0x12345678 in the DONE cycle (cycle 5).
- Back-to-back: write 0xDEADBEEF at 1024, then read 1024 issued the cycle after ready=1.
  - read_data=0xDEADBEEF.
  - The DONE→IDLE sequence shows no spurious extra access.
- rd_en and wr_en both high at address 1040 with write_data=0xCAFEF00D → a write occurs (mem[8]=0xF00D, mem[9]=0xCAFE) and read_data is unchanged.
- Assert rst=0 during WR_HI → WE_N=1 and DQ=Z immediately, state IDLE, no DONE cycle; the next request after release completes normally.
